// File: rtl/rv_hazard_pkg.sv
// Shared types and sizing helpers for the hazard/forwarding controller and its scoreboard.
package rv_hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_t;

  // Flush-window counter width; holds FLUSH_XTRA values up to 15.
  localparam int FLUSH_CNT_W = 4;

  function automatic int ridx(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // Forward-select width: one code per forwarding stage plus one for the register file.
  function automatic int fsel_w(input int stages);
    return (stages > 0) ? $clog2(stages + 1) : 1;
  endfunction

endpackage

// File: rtl/rv_hazard_unit_if.sv
// Datapath <-> hazard unit bundle: master is the pipeline datapath, slave is the hazard unit.
interface rv_hazard_unit_if #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int FWD_STAGES = 2
);
  import rv_hazard_pkg::*;
  localparam int RIDX = ridx(NREG);

  logic                       id_valid;
  logic [RIDX-1:0]            id_rs1;
  logic [RIDX-1:0]            id_rs2;
  logic                       id_use1;
  logic                       id_use2;
  logic [RIDX-1:0]            id_rd;
  logic                       id_we;
  logic                       ex_valid;
  logic [RIDX-1:0]            ex_rs1;
  logic [RIDX-1:0]            ex_rs2;
  logic [RIDX-1:0]            ex_rd;
  logic                       ex_memread;
  logic                       ex_long;
  logic [XLEN-1:0]            ex_rs1_data;
  logic [XLEN-1:0]            ex_rs2_data;
  logic [FWD_STAGES-1:0]      fwd_we;
  logic [FWD_STAGES*RIDX-1:0] fwd_rd;
  logic [FWD_STAGES*XLEN-1:0] fwd_data;
  logic                       lng_done;
  logic [RIDX-1:0]            lng_rd;
  logic                       redirect;
  logic [XLEN-1:0]            ex_op_a;
  logic [XLEN-1:0]            ex_op_b;
  logic                       stall_if;
  logic                       stall_id;
  logic                       bubble_ex;
  logic                       flush_if;
  logic                       flush_id;
  logic                       flush_ex;
  logic [NREG-1:0]            sb_busy;
  logic [1:0]                 hz_state;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_we,
    output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_memread, ex_long, ex_rs1_data, ex_rs2_data,
    output fwd_we, fwd_rd, fwd_data, lng_done, lng_rd, redirect,
    input  ex_op_a, ex_op_b, stall_if, stall_id, bubble_ex,
    input  flush_if, flush_id, flush_ex, sb_busy, hz_state
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_we,
    input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_memread, ex_long, ex_rs1_data, ex_rs2_data,
    input  fwd_we, fwd_rd, fwd_data, lng_done, lng_rd, redirect,
    output ex_op_a, ex_op_b, stall_if, stall_id, bubble_ex,
    output flush_if, flush_id, flush_ex, sb_busy, hz_state
  );

endinterface

// File: rtl/rv_scoreboard.sv
// NREG-bit busy register with one set port and one clear port per cycle; set wins on a collision.
// Entry 0 is hardwired idle (x0 never has a pending writer).
module rv_scoreboard
  import rv_hazard_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  set_vld,
  input  logic [ridx(NREG)-1:0] set_idx,
  input  logic                  clr_vld,
  input  logic [ridx(NREG)-1:0] clr_idx,
  output logic [NREG-1:0]       busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_q;
    if (clr_vld) busy_nxt[clr_idx] = 1'b0;
    if (set_vld) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) busy_q <= '0;
    else      busy_q <= busy_nxt;
  end

  assign busy = busy_q;

endmodule

// File: rtl/rv_hazard_unit.sv
// Operand forwarding, load-use/long-op/scoreboard stalls and stretched redirect flush for an in-order RV32I pipe.
// HZ_PERF_EN adds saturating stall-cycle and redirect counters (perf_stall, perf_flush).
module rv_hazard_unit
  import rv_hazard_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int FWD_STAGES = 2,
  parameter int FLUSH_XTRA = 0
) (
  input  logic            Clk,
  input  logic            Rst,
  rv_hazard_unit_if.slave hz
`ifdef HZ_PERF_EN
  ,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush
`endif
);

  localparam int RIDX = ridx(NREG);
  localparam int SELW = fsel_w(FWD_STAGES);
  localparam logic [SELW-1:0] SEL_RF = SELW'(FWD_STAGES);

  // Youngest matching stage wins, so scan oldest-first and let later hits overwrite.
  function automatic logic [SELW-1:0] fwd_sel(input logic [RIDX-1:0]            rs,
                                               input logic [FWD_STAGES-1:0]      we,
                                               input logic [FWD_STAGES*RIDX-1:0] rd);
    fwd_sel = SEL_RF;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (we[k] && (rd[k*RIDX +: RIDX] != '0) && (rd[k*RIDX +: RIDX] == rs))
        fwd_sel = SELW'(k);
    end
  endfunction

  function automatic logic [XLEN-1:0] fwd_mux(input logic [SELW-1:0]            sel,
                                               input logic [XLEN-1:0]            rf,
                                               input logic [FWD_STAGES*XLEN-1:0] fd);
    fwd_mux = rf;
    for (int k = 0; k < FWD_STAGES; k++) begin
      if (sel == SELW'(k)) fwd_mux = fd[k*XLEN +: XLEN];
    end
  endfunction

  logic [SELW-1:0] sel_a;
  logic [SELW-1:0] sel_b;

  assign sel_a      = fwd_sel(hz.ex_rs1, hz.fwd_we, hz.fwd_rd);
  assign sel_b      = fwd_sel(hz.ex_rs2, hz.fwd_we, hz.fwd_rd);
  assign hz.ex_op_a = fwd_mux(sel_a, hz.ex_rs1_data, hz.fwd_data);
  assign hz.ex_op_b = fwd_mux(sel_b, hz.ex_rs2_data, hz.fwd_data);

  logic [NREG-1:0] busy;
  logic            sb_set;
  logic            ex_match;
  logic            lu;
  logic            lg;
  logic            sb;
  logic            hz_any;

  assign sb_set = hz.ex_valid && hz.ex_long && (hz.ex_rd != '0) && !hz.redirect;

  rv_scoreboard #(.NREG(NREG)) u_sb (
    .Clk     (Clk),
    .Rst     (Rst),
    .set_vld (sb_set),
    .set_idx (hz.ex_rd),
    .clr_vld (hz.lng_done),
    .clr_idx (hz.lng_rd),
    .busy    (busy)
  );

  // The scoreboard bit only appears a cycle after dispatch, so the EX-stage long op is matched directly.
  assign ex_match = hz.id_valid && hz.ex_valid && (hz.ex_rd != '0) &&
                    ((hz.id_use1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use2 && (hz.id_rs2 == hz.ex_rd)));
  assign lu       = ex_match && hz.ex_memread;
  assign lg       = ex_match && hz.ex_long;
  assign sb       = hz.id_valid && ((hz.id_use1 && busy[hz.id_rs1]) ||
                                    (hz.id_use2 && busy[hz.id_rs2]) ||
                                    (hz.id_we   && busy[hz.id_rd]));
  assign hz_any   = lu || lg || sb;

  hz_state_t              state_q;
  hz_state_t              state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt_nxt;
  logic                   stall;
  logic                   flush_front;
  logic                   flush_back;

  always_comb begin
    flush_cnt_nxt = flush_cnt;
    if (hz.redirect)            flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_XTRA);
    else if (flush_cnt != '0)   flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
  end

  always_comb begin
    state_nxt   = state_q;
    stall       = 1'b0;
    flush_front = hz.redirect || (flush_cnt != '0);
    flush_back  = hz.redirect;
    case (state_q)
      HZ_RUN, HZ_STALL: begin
        if (hz.redirect)      state_nxt = (FLUSH_XTRA > 0) ? HZ_FLUSH : HZ_RUN;
        else if (hz_any)      state_nxt = HZ_STALL;
        else                  state_nxt = HZ_RUN;
      end
      HZ_FLUSH: begin
        if (!hz.redirect && (flush_cnt_nxt == '0)) state_nxt = HZ_RUN;
      end
      default:                state_nxt = HZ_RUN;
    endcase
    // A redirect or an open flush window discards the ID instruction, so its hazard is moot.
    stall = hz_any && !hz.redirect && (state_q != HZ_FLUSH);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= HZ_RUN;
      flush_cnt <= '0;
    end else begin
      state_q   <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  assign hz.stall_if  = Rst && stall;
  assign hz.stall_id  = Rst && stall;
  assign hz.bubble_ex = Rst && stall;
  assign hz.flush_if  = Rst && flush_front;
  assign hz.flush_id  = Rst && flush_back;
  assign hz.flush_ex  = Rst && flush_back;
  assign hz.sb_busy   = busy;
  assign hz.hz_state  = state_q;

`ifdef HZ_PERF_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (stall && !(&perf_stall))       perf_stall <= perf_stall + 32'd1;
      if (hz.redirect && !(&perf_flush)) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Directed pipeline scenarios followed by random traffic, all checked against a cycle-level reference model.
module tb_rv_hazard_unit;
  import rv_hazard_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int FS   = 2;
  localparam int FX   = 2;
  localparam int RIDX = 5;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  rv_hazard_unit_if #(.XLEN(XLEN), .NREG(NREG), .FWD_STAGES(FS)) bus ();

`ifdef HZ_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
  int          m_pstall;
  int          m_pflush;
`endif

  rv_hazard_unit #(.XLEN(XLEN), .NREG(NREG), .FWD_STAGES(FS), .FLUSH_XTRA(FX)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (bus)
`ifdef HZ_PERF_EN
    ,
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  // Reference state: pending long-op destinations, cycles since the last redirect, last cycle's hazard view.
  bit m_busy [NREG];
  int since;
  bit p_hz, p_redir, p_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    since   = 100;
    p_hz    = 1'b0;
    p_redir = 1'b0;
    p_win   = 1'b0;
`ifdef HZ_PERF_EN
    m_pstall = 0;
    m_pflush = 0;
`endif
  endtask

  function automatic bit id_reads(input logic [RIDX-1:0] r);
    return bus.id_valid && ((bus.id_use1 && bus.id_rs1 == r) || (bus.id_use2 && bus.id_rs2 == r));
  endfunction

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use1 = 0; bus.id_use2 = 0;
    bus.id_rd = '0; bus.id_we = 0;
    bus.ex_valid = 0; bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0;
    bus.ex_memread = 0; bus.ex_long = 0;
    bus.ex_rs1_data = 32'h1111_0001; bus.ex_rs2_data = 32'h2222_0002;
    bus.fwd_we = '0; bus.fwd_rd = '0; bus.fwd_data = '0;
    bus.lng_done = 0; bus.lng_rd = '0; bus.redirect = 0;
  endtask

  // Compare every output against the model at the falling edge, then advance the model one cycle.
  task automatic cyc();
    logic [XLEN-1:0] ea, eb;
    logic [RIDX-1:0] rdk;
    logic [31:0]     ebusy;
    bit              fa, fb, lu, lg, sbh, hzv, win, st, fl;
    int              est;
    @(negedge Clk);
    if (!Rst) model_reset();
    ea = bus.ex_rs1_data; eb = bus.ex_rs2_data; fa = 0; fb = 0;
    for (int k = 0; k < FS; k++) begin
      rdk = bus.fwd_rd[k*RIDX +: RIDX];
      if (bus.fwd_we[k] && rdk != 0) begin
        if (!fa && rdk == bus.ex_rs1) begin ea = bus.fwd_data[k*XLEN +: XLEN]; fa = 1; end
        if (!fb && rdk == bus.ex_rs2) begin eb = bus.fwd_data[k*XLEN +: XLEN]; fb = 1; end
      end
    end
    lu  = bus.ex_valid && bus.ex_memread && bus.ex_rd != 0 && id_reads(bus.ex_rd);
    lg  = bus.ex_valid && bus.ex_long && bus.ex_rd != 0 && id_reads(bus.ex_rd);
    sbh = bus.id_valid && ((bus.id_use1 && m_busy[bus.id_rs1]) ||
                           (bus.id_use2 && m_busy[bus.id_rs2]) ||
                           (bus.id_we && m_busy[bus.id_rd]));
    hzv = lu || lg || sbh;
    win = (since >= 1) && (since <= FX);
    est = win ? 2 : ((p_hz && !p_redir && !p_win) ? 1 : 0);
    st  = Rst && !bus.redirect && !win && hzv;
    fl  = Rst && (bus.redirect || win);
    for (int i = 0; i < NREG; i++) ebusy[i] = m_busy[i];
    chk("op_a", bus.ex_op_a, ea);
    chk("op_b", bus.ex_op_b, eb);
    chk("stall_if", 32'(bus.stall_if), 32'(st));
    chk("stall_id", 32'(bus.stall_id), 32'(st));
    chk("bubble_ex", 32'(bus.bubble_ex), 32'(st));
    chk("flush_if", 32'(bus.flush_if), 32'(fl));
    chk("flush_id", 32'(bus.flush_id), 32'(Rst && bus.redirect));
    chk("flush_ex", 32'(bus.flush_ex), 32'(Rst && bus.redirect));
    chk("sb_busy", bus.sb_busy, ebusy);
    chk("hz_state", 32'(bus.hz_state), est);
`ifdef HZ_PERF_EN
    chk("perf_stall", perf_stall, m_pstall);
    chk("perf_flush", perf_flush, m_pflush);
`endif
    if (Rst) begin
`ifdef HZ_PERF_EN
      if (st) m_pstall++;
      if (bus.redirect) m_pflush++;
`endif
      if (bus.lng_done) m_busy[bus.lng_rd] = 1'b0;
      if (bus.ex_valid && bus.ex_long && bus.ex_rd != 0 && !bus.redirect) m_busy[bus.ex_rd] = 1'b1;
      since   = bus.redirect ? 1 : ((since < 100) ? since + 1 : since);
      p_hz    = hzv;
      p_redir = bus.redirect;
      p_win   = win;
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    model_reset();
    idle();
    cyc();
    cyc();
    Rst = 1'b1;
    cyc();

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    bus.ex_valid = 1; bus.ex_memread = 1; bus.ex_rd = 5'd5;
    bus.id_valid = 1; bus.id_use1 = 1; bus.id_rs1 = 5'd5; bus.id_use2 = 1; bus.id_rs2 = 5'd1;
    bus.id_we = 1; bus.id_rd = 5'd6;
    #1;
    chk("lu_stall", 32'(bus.stall_if), 1);
    chk("lu_bubble", 32'(bus.bubble_ex), 1);
    chk("lu_state0", 32'(bus.hz_state), HZ_RUN);
    cyc();
    bus.ex_valid = 0; bus.ex_memread = 0;
    #1;
    chk("lu_release", 32'(bus.stall_if), 0);
    chk("lu_state1", 32'(bus.hz_state), HZ_STALL);
    cyc();
    idle();
    #1;
    chk("lu_state2", 32'(bus.hz_state), HZ_RUN);
`ifdef HZ_PERF_EN
    chk("perf_one", perf_stall, 1);
`endif
    cyc();

    // Forward priority: youngest stage wins; x0 never forwards.
    bus.fwd_we = 2'b11; bus.fwd_rd = {5'd3, 5'd3}; bus.fwd_data = {32'h0000_5555, 32'h0000_AAAA};
    bus.ex_rs1 = 5'd3; bus.ex_rs1_data = 32'h0000_1234;
    #1;
    chk("fwd_young", bus.ex_op_a, 32'h0000_AAAA);
    cyc();
    bus.fwd_rd = {5'd9, 5'd3}; bus.ex_rs2 = 5'd9;
    #1;
    chk("fwd_old", bus.ex_op_b, 32'h0000_5555);
    cyc();
    bus.fwd_rd = '0; bus.ex_rs1 = '0;
    #1;
    chk("fwd_x0", bus.ex_op_a, 32'h0000_1234);
    cyc();
    idle();

    // Long op to x7, consumer waits for its writeback.
    bus.ex_valid = 1; bus.ex_long = 1; bus.ex_rd = 5'd7;
    cyc();
    idle();
    bus.id_valid = 1; bus.id_use1 = 1; bus.id_rs1 = 5'd7;
    #1;
    chk("busy7_set", 32'(bus.sb_busy[7]), 1);
    chk("sb_stall", 32'(bus.stall_if), 1);
    cyc();
    cyc();
    bus.lng_done = 1; bus.lng_rd = 5'd7;
    #1;
    chk("sb_stall_done", 32'(bus.stall_if), 1);
    cyc();
    bus.lng_done = 0;
    #1;
    chk("sb_resume", 32'(bus.stall_if), 0);
    chk("busy7_clr", bus.sb_busy, 0);
    cyc();
    idle();

    // Same-cycle clear and new dispatch to x7: set wins.
    bus.ex_valid = 1; bus.ex_long = 1; bus.ex_rd = 5'd7;
    cyc();
    bus.lng_done = 1; bus.lng_rd = 5'd7;
    cyc();
    idle();
    #1;
    chk("set_wins", 32'(bus.sb_busy[7]), 1);
    bus.lng_done = 1; bus.lng_rd = 5'd7;
    cyc();
    idle();

    // Redirect window with FLUSH_XTRA=2, then a restart mid-window.
    bus.redirect = 1;
    #1;
    chk("rd_flush_id", 32'(bus.flush_id), 1);
    cyc();
    bus.redirect = 0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk("win_flush_if", 32'(bus.flush_if), (c <= FX) ? 1 : 0);
      chk("win_flush_ex", 32'(bus.flush_ex), 0);
      cyc();
    end
    bus.redirect = 1;
    cyc();
    bus.redirect = 0;
    cyc();
    bus.redirect = 1;
    cyc();
    bus.redirect = 0;
    bus.ex_valid = 1; bus.ex_memread = 1; bus.ex_rd = 5'd4;
    bus.id_valid = 1; bus.id_use1 = 1; bus.id_rs1 = 5'd4;
    #1;
    chk("restart_if", 32'(bus.flush_if), 1);
    chk("flush_nostall", 32'(bus.stall_if), 0);
    chk("flush_state", 32'(bus.hz_state), HZ_FLUSH);
    cyc();
    idle();
    #1;
    chk("restart_if2", 32'(bus.flush_if), 1);
    cyc();
    #1;
    chk("restart_end", 32'(bus.flush_if), 0);
    cyc();

    // Reset while stalled on a busy x7.
    bus.ex_valid = 1; bus.ex_long = 1; bus.ex_rd = 5'd7;
    cyc();
    idle();
    bus.id_valid = 1; bus.id_use1 = 1; bus.id_rs1 = 5'd7;
    cyc();
    cyc();
    Rst = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.stall_if), 0);
    chk("rst_busy", bus.sb_busy, 0);
    chk("rst_state", 32'(bus.hz_state), HZ_RUN);
    cyc();
    Rst = 1'b1;
    cyc();
    idle();
    cyc();

    for (int n = 0; n < 800; n++) begin
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.id_rs1      = RIDX'($urandom_range(0, 7));
      bus.id_rs2      = RIDX'($urandom_range(0, 7));
      bus.id_use1     = $urandom_range(0, 1) == 1;
      bus.id_use2     = $urandom_range(0, 1) == 1;
      bus.id_rd       = RIDX'($urandom_range(0, 7));
      bus.id_we       = $urandom_range(0, 1) == 1;
      bus.ex_valid    = ($urandom_range(0, 3) != 0);
      bus.ex_rs1      = RIDX'($urandom_range(0, 7));
      bus.ex_rs2      = RIDX'($urandom_range(0, 7));
      bus.ex_rd       = RIDX'($urandom_range(0, 7));
      bus.ex_memread  = ($urandom_range(0, 3) == 0);
      bus.ex_long     = ($urandom_range(0, 3) == 0);
      bus.ex_rs1_data = $urandom;
      bus.ex_rs2_data = $urandom;
      bus.fwd_we      = FS'($urandom);
      bus.fwd_rd      = {RIDX'($urandom_range(0, 7)), RIDX'($urandom_range(0, 7))};
      bus.fwd_data    = {$urandom, $urandom};
      bus.lng_done    = ($urandom_range(0, 3) == 0);
      bus.lng_rd      = RIDX'($urandom_range(0, 7));
      bus.redirect    = ($urandom_range(0, 9) == 0);
      Rst             = ($urandom_range(0, 199) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
